// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, opcode/funct constants and control bundle
// for the single-cycle MIPS-subset core.
package mips_pkg;

  localparam int PC_WIDTH = 32;
  localparam int DWIDTH   = 32;
  localparam int AWIDTH   = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    reg_dst;
    logic    alu_src;
    logic    mem_write;
    logic    mem_to_reg;
    logic    branch;
    logic    jump;
    alu_op_e alu_op;
  } ctrl_t;

endpackage

// File: rtl/mips_datapath.sv
// mips_datapath: PC, instruction/data memories, register file, ALU
// and next-PC selection, steered by the decoded control bundle.
module mips_datapath #(
  parameter int PC_WIDTH   = mips_pkg::PC_WIDTH,
  parameter int DWIDTH     = mips_pkg::DWIDTH,
  parameter int AWIDTH     = mips_pkg::AWIDTH,
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  logic                p_clk,
  input  logic                p_rst,
  input  logic                p_i_ce,
  input  mips_pkg::ctrl_t     ctrl,
  output logic [5:0]          op,
  output logic [5:0]          fn,
  output logic [PC_WIDTH-1:0] pc,
  output logic [DWIDTH-1:0]   wb_data
);
  import mips_pkg::*;

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  logic [31:0]         imem [IMEM_DEPTH];
  logic [DWIDTH-1:0]   dmem [DMEM_DEPTH];
  logic [DWIDTH-1:0]   rf_q [2**AWIDTH];
  logic [PC_WIDTH-1:0] pc_q, pc_d, pc4;

  logic [31:0]       instr;
  logic [AWIDTH-1:0] rs, rt, rd, wa;
  logic [DWIDTH-1:0] imm_ext, rs_val, rt_val;
  logic [DWIDTH-1:0] alu_b, alu_y, rdata;
  logic [DAW-1:0]    daddr;
  logic              rf_we;
  logic              es_o_zero;
  logic              es_is_change_pc;

  assign instr   = imem[pc_q[IAW+1:2]];
  assign op      = instr[31:26];
  assign fn      = instr[5:0];
  assign rs      = instr[25:21];
  assign rt      = instr[20:16];
  assign rd      = instr[15:11];
  assign imm_ext = {{(DWIDTH-16){instr[15]}}, instr[15:0]};

  assign rs_val = (rs == '0) ? '0 : rf_q[rs];
  assign rt_val = (rt == '0) ? '0 : rf_q[rt];
  assign alu_b  = ctrl.alu_src ? imm_ext : rt_val;

  always_comb begin
    alu_y = '0;
    unique case (ctrl.alu_op)
      ALU_ADD: alu_y = rs_val + alu_b;
      ALU_SUB: alu_y = rs_val - alu_b;
      ALU_AND: alu_y = rs_val & alu_b;
      ALU_OR:  alu_y = rs_val | alu_b;
      ALU_SLT: alu_y = {{(DWIDTH-1){1'b0}},
                        $signed(rs_val) < $signed(alu_b)};
      default: alu_y = '0;
    endcase
  end

  assign es_o_zero       = (alu_y == '0);
  assign es_is_change_pc = (ctrl.branch & es_o_zero) | ctrl.jump;

  assign daddr   = alu_y[DAW+1:2];
  assign rdata   = dmem[daddr];
  assign wb_data = ctrl.mem_to_reg ? rdata : alu_y;

  assign wa    = ctrl.reg_dst ? rd : rt;
  assign rf_we = p_i_ce & ctrl.reg_write & (wa != '0);
  assign pc4   = pc_q + 4;
  assign pc    = pc_q;

  always_comb begin
    pc_d = pc_q;
    if (p_i_ce) begin
      pc_d = pc4;
      if (es_is_change_pc)
        pc_d = ctrl.jump
             ? {pc4[PC_WIDTH-1:28], instr[25:0], 2'b00}
             : pc4 + {imm_ext[PC_WIDTH-3:0], 2'b00};
    end
  end

  always_ff @(posedge p_clk or negedge p_rst) begin
    if (!p_rst) begin
      pc_q <= '0;
      for (int i = 0; i < 2**AWIDTH; i++) rf_q[i] <= '0;
    end else begin
      pc_q <= pc_d;
      if (rf_we) rf_q[wa] <= wb_data;
    end
  end

  // Data memory keeps its contents across reset.
  always_ff @(posedge p_clk) begin
    if (p_rst && p_i_ce && ctrl.mem_write) dmem[daddr] <= rt_val;
  end

endmodule

// File: rtl/mips_processor.sv
// mips_processor: single-cycle MIPS-subset CPU top.
// Decodes control here; storage and execution live in mips_datapath.
module mips_processor #(
  parameter int PC_WIDTH   = mips_pkg::PC_WIDTH,
  parameter int DWIDTH     = mips_pkg::DWIDTH,
  parameter int AWIDTH     = mips_pkg::AWIDTH,
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256,
  parameter     IMEM_FILE  = "./memory/instr.mem"
) (
  input  logic                p_clk,
  input  logic                p_rst,
  input  logic                p_i_ce,
  output logic [PC_WIDTH-1:0] p_o_pc,
  output logic [DWIDTH-1:0]   p_wb_data
);
  import mips_pkg::*;

  ctrl_t      ctrl;
  logic [5:0] op, fn;

  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALU_ADD;
    unique case (1'b1)
      op == OP_RTYPE: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        unique case (1'b1)
          fn == FN_ADD: ctrl.alu_op = ALU_ADD;
          fn == FN_SUB: ctrl.alu_op = ALU_SUB;
          fn == FN_AND: ctrl.alu_op = ALU_AND;
          fn == FN_OR:  ctrl.alu_op = ALU_OR;
          fn == FN_SLT: ctrl.alu_op = ALU_SLT;
          default:      ctrl.reg_write = 1'b0;
        endcase
      end
      op == OP_ADDI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      op == OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      op == OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      op == OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_SUB;
      end
      op == OP_J: ctrl.jump = 1'b1;
      default: ;
    endcase
  end

  mips_datapath #(
    .PC_WIDTH   (PC_WIDTH),
    .DWIDTH     (DWIDTH),
    .AWIDTH     (AWIDTH),
    .IMEM_DEPTH (IMEM_DEPTH),
    .DMEM_DEPTH (DMEM_DEPTH)
  ) d (
    .p_clk   (p_clk),
    .p_rst   (p_rst),
    .p_i_ce  (p_i_ce),
    .ctrl    (ctrl),
    .op      (op),
    .fn      (fn),
    .pc      (p_o_pc),
    .wb_data (p_wb_data)
  );

endmodule

// File: tb/tb_mips_processor.sv
// tb_mips_processor: directed program with an ISA-level model
// compared every cycle, plus hand-computed literal checks.
module tb_mips_processor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce  = 1'b0;
  logic [31:0] pc_o, wb_o;

  mips_processor p (
    .p_clk     (clk),
    .p_rst     (rst),
    .p_i_ce    (ce),
    .p_o_pc    (pc_o),
    .p_wb_data (wb_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  logic [31:0] prog  [256];
  logic [31:0] m_reg [32];
  logic [31:0] m_mem [256];
  logic [31:0] m_pc = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_r(input int rs, rt, rd,
                                        input logic [5:0] f);
    logic [4:0] a, b, c;
    a = rs[4:0]; b = rt[4:0]; c = rd[4:0];
    return {6'h00, a, b, c, 5'h00, f};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] o,
                                        input int rs, rt, imm);
    logic [4:0]  a, b;
    logic [15:0] k;
    a = rs[4:0]; b = rt[4:0]; k = imm[15:0];
    return {o, a, b, k};
  endfunction

  // ISA-level interpretation of the instruction at pc.
  function automatic void exec(
    input  logic [31:0] pc,
    output logic [31:0] wb, npc,
    output bit wbv, chg, is_beq, eq, rwe, mwe,
    output int wa, output logic [31:0] ma, md);
    logic [31:0] ins, a, b, imm;
    ins = prog[pc[9:2]];
    a   = m_reg[ins[25:21]];
    b   = m_reg[ins[20:16]];
    imm = {{16{ins[15]}}, ins[15:0]};
    wb = a + b; npc = pc + 4; wbv = 1; chg = 0; is_beq = 0;
    eq = 0; rwe = 0; mwe = 0; wa = 0; ma = a + imm; md = b;
    case (ins[31:26])
      6'h00: begin
        wa = int'(ins[15:11]); rwe = 1;
        case (ins[5:0])
          6'h20: wb = a + b;
          6'h22: wb = a - b;
          6'h24: wb = a & b;
          6'h25: wb = a | b;
          6'h2A: wb = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: begin rwe = 0; wbv = 0; end
        endcase
      end
      6'h08: begin wb = a + imm; rwe = 1; wa = int'(ins[20:16]); end
      6'h23: begin wb = m_mem[ma[9:2]]; rwe = 1; wa = int'(ins[20:16]); end
      6'h2B: begin wb = ma; mwe = 1; end
      6'h04: begin
        wb = a - b; is_beq = 1; eq = (a == b); chg = eq;
        if (eq) npc = pc + 4 + (imm << 2);
      end
      6'h02: begin
        wbv = 0; chg = 1;
        npc = {npc[31:28], ins[25:0], 2'b00};
      end
      default: wbv = 0;
    endcase
    if (wa == 0) rwe = 0;
  endfunction

  always @(posedge clk) begin
    logic [31:0] wb, npc, ma, md;
    bit wbv, chg, ib, eq, rwe, mwe;
    int wa;
    if (rst === 1'b1 && ce === 1'b1) begin
      exec(m_pc, wb, npc, wbv, chg, ib, eq, rwe, mwe, wa, ma, md);
      if (rwe) m_reg[wa] = wb;
      if (mwe) m_mem[ma[9:2]] = md;
      m_pc = npc;
    end
  end

  always @(negedge rst) begin
    m_pc = '0;
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
  end

  always @(negedge clk) begin
    logic [31:0] wb, npc, ma, md;
    bit wbv, chg, ib, eq, rwe, mwe;
    int wa;
    if (chk_en) begin
      exec(m_pc, wb, npc, wbv, chg, ib, eq, rwe, mwe, wa, ma, md);
      chk("model_pc", pc_o, m_pc);
      if (wbv) chk("model_wb", wb_o, wb);
      chk("model_chg", {31'b0, p.d.es_is_change_pc}, {31'b0, chg});
      if (ib) chk("model_zero", {31'b0, p.d.es_o_zero}, {31'b0, eq});
    end
  end

  logic [31:0] seq [13];

  initial begin
    for (int i = 0; i < 256; i++) begin prog[i] = '0; m_mem[i] = '0; end
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    prog[0]  = enc_i(6'h08, 0, 1, 5);
    prog[1]  = enc_i(6'h08, 0, 2, 7);
    prog[2]  = enc_r(1, 2, 3, 6'h20);
    prog[3]  = enc_r(1, 2, 4, 6'h22);
    prog[4]  = enc_i(6'h04, 1, 1, 2);
    prog[5]  = enc_i(6'h08, 0, 9, 99);
    prog[6]  = enc_i(6'h08, 0, 9, 98);
    prog[7]  = enc_r(1, 2, 5, 6'h2A);
    prog[8]  = enc_i(6'h04, 1, 2, 5);
    prog[9]  = enc_i(6'h2B, 0, 3, 0);
    prog[10] = enc_i(6'h23, 0, 6, 0);
    prog[11] = enc_r(6, 0, 7, 6'h20);
    prog[12] = enc_i(6'h08, 0, 0, 9);
    prog[13] = enc_r(0, 0, 8, 6'h20);
    prog[14] = {6'h02, 26'd0};
    for (int i = 0; i < 256; i++) p.d.imem[i] = prog[i];

    seq = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h1C, 32'h20, 32'h24,
            32'h28, 32'h2C, 32'h30, 32'h34, 32'h38, 32'h00};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_pc", pc_o, 32'h0);
    chk("reset_wb", wb_o, 32'd5);
    chk("reset_r1", p.d.rf_q[1], 32'h0);
    #1 rst = 1'b1; ce = 1'b1; chk_en = 1'b1;

    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      chk("pc_seq", pc_o, seq[c]);
      case (seq[c])
        32'h04: chk("addi_7", wb_o, 32'd7);
        32'h08: chk("add_12", wb_o, 32'd12);
        32'h0C: chk("sub_neg2", wb_o, 32'hFFFF_FFFE);
        32'h10: begin
          chk("beq_zero", {31'b0, p.d.es_o_zero}, 32'd1);
          chk("beq_chg", {31'b0, p.d.es_is_change_pc}, 32'd1);
        end
        32'h1C: chk("slt_1", wb_o, 32'd1);
        32'h20: begin
          chk("bne_zero", {31'b0, p.d.es_o_zero}, 32'd0);
          chk("bne_chg", {31'b0, p.d.es_is_change_pc}, 32'd0);
        end
        32'h28: chk("lw_12", wb_o, 32'd12);
        32'h2C: chk("add_lw_12", wb_o, 32'd12);
        32'h30: chk("addi_r0_wb", wb_o, 32'd9);
        32'h34: chk("add_r0_0", wb_o, 32'd0);
        32'h38: chk("j_chg", {31'b0, p.d.es_is_change_pc}, 32'd1);
        default: ;
      endcase
    end

    #1 ce = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("hold_pc", pc_o, 32'h0);
      chk("hold_r1", p.d.rf_q[1], 32'd5);
    end
    chk("hold_r3", p.d.rf_q[3], 32'd12);
    chk("hold_r7", p.d.rf_q[7], 32'd12);
    chk("hold_r0", p.d.rf_q[0], 32'd0);
    chk("hold_r9", p.d.rf_q[9], 32'd0);

    #1 ce = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 chk("pre_rst_pc", pc_o, 32'h10);
    rst = 1'b0;
    #1 chk("async_rst_pc", pc_o, 32'h0);
    chk("async_rst_r1", p.d.rf_q[1], 32'h0);
    @(negedge clk);
    #1 rst = 1'b1;
    repeat (16) @(negedge clk);
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
